wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 91 +++++++++
 tb/tb_wb_regfile.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage register plus the general-purpose register array.
// Register 0 always reads as zero, and the pending WB write is bypassed
// to both read ports.
`timescale 1ns/1ps

module wb_regfile #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wd_i,
  input  logic          wreg_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic [AW-1:0] wb_wd_o,
  output logic          wb_wreg_o,
  output logic [DW-1:0] wb_wdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Resolve one read port. Reset and disabled ports return zero, and
  // register 0 returns zero. A write sitting in WB takes precedence over
  // the array so that ID sees the newest value one edge early.
  function automatic logic [DW-1:0] read_port(
    input logic          rst_n_now,
    input logic          re,
    input logic [AW-1:0] addr,
    input logic          pend_wreg,
    input logic [AW-1:0] pend_wd,
    input logic [DW-1:0] pend_wdata,
    input logic [DW-1:0] array_word
  );
    logic [DW-1:0] result;
    result = '0;
    if (rst_n_now && re && (addr != '0)) begin
      if (pend_wreg && (pend_wd == addr)) begin
        result = pend_wdata;
      end else begin
        result = array_word;
      end
    end
    return result;
  endfunction

  // WB stage register: flush inserts a bubble and wins over stall; stall holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (flush_i) begin
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (!stall_i) begin
      wb_wd_o    <= wd_i;
      wb_wreg_o  <= wreg_i;
      wb_wdata_o <= wdata_i;
    end
  end

  // Array commit from WB. This ignores stall, so a held entry simply
  // rewrites the same value each edge. Entry 0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wb_wreg_o && (wb_wd_o != '0)) begin
      mem[wb_wd_o] <= wb_wdata_o;
    end
  end

  // Two independent combinational read ports.
  always_comb begin
    rdata1 = read_port(rst, re1, raddr1, wb_wreg_o, wb_wd_o, wb_wdata_o, mem[raddr1]);
    rdata2 = read_port(rst, re2, raddr2, wb_wreg_o, wb_wd_o, wb_wdata_o, mem[raddr2]);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile. A driver applies stimulus and queues the
// expected outputs from a reference model. A monitor compares them on the
// falling edge.
`timescale 1ns/1ps

module tb_wb_regfile;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] wd_i;
  logic          wreg_i;
  logic [DW-1:0] wdata_i;
  logic          stall_i;
  logic          flush_i;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [AW-1:0] wb_wd_o;
  logic          wb_wreg_o;
  logic [DW-1:0] wb_wdata_o;

  wb_regfile #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wd_i      (wd_i),
    .wreg_i    (wreg_i),
    .wdata_i   (wdata_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .re1       (re1),
    .raddr1    (raddr1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .wb_wd_o   (wb_wd_o),
    .wb_wreg_o (wb_wreg_o),
    .wb_wdata_o(wb_wdata_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared;
  int   n_mismatched;

  // Reference model. Architectural registers plus the one write that has
  // been accepted but not yet committed.
  logic [DW-1:0] ref_mem [NREG];
  logic [AW-1:0] ref_wd;
  logic          ref_wreg;
  logic [DW-1:0] ref_wdata;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
    ref_wd    = '0;
    ref_wreg  = 1'b0;
    ref_wdata = '0;
  endtask

  // A register's visible value is its newest accepted write, or zero.
  function automatic logic [DW-1:0] model_read(input logic re, input logic [AW-1:0] addr);
    logic [DW-1:0] v;
    v = ref_mem[addr];
    if (ref_wreg && ref_wd == addr) v = ref_wdata;
    if (!rst || !re || addr == 0) v = '0;
    return v;
  endfunction

  // One rising edge: commit the pending write, then advance the WB slot.
  task automatic model_edge();
    if (ref_wreg && ref_wd != 0) ref_mem[ref_wd] = ref_wdata;
    if (flush_i) begin
      ref_wd = '0; ref_wreg = 1'b0; ref_wdata = '0;
    end else if (!stall_i) begin
      ref_wd = wd_i; ref_wreg = wreg_i; ref_wdata = wdata_i;
    end
  endtask

  task automatic push_expect();
    sb_q.push_back('{0, model_read(re1, raddr1)});
    sb_q.push_back('{1, model_read(re2, raddr2)});
    sb_q.push_back('{2, 32'(ref_wd)});
    sb_q.push_back('{3, 32'(ref_wreg)});
    sb_q.push_back('{4, ref_wdata});
  endtask

  // Drive one cycle's inputs, queue expectations, and step the model on the edge.
  task automatic apply_stimulus(
    input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] wdata,
    input logic stall, input logic flush,
    input logic r1, input logic [AW-1:0] a1,
    input logic r2, input logic [AW-1:0] a2
  );
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    stall_i = stall; flush_i = flush;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Assert reset between edges. Outputs are checked while it is low.
  // Reset is released before the next rising edge.
  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    model_clear();
    push_expect();
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_output(input exp_t e);
    logic [31:0] act;
    string       name;
    case (e.sel)
      0: begin act = rdata1;            name = "rdata1";     end
      1: begin act = rdata2;            name = "rdata2";     end
      2: begin act = 32'(wb_wd_o);      name = "wb_wd_o";    end
      3: begin act = 32'(wb_wreg_o);    name = "wb_wreg_o";  end
      default: begin act = wb_wdata_o;  name = "wb_wdata_o"; end
    endcase
    n_compared++;
    if (act !== e.exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, e.exp);
    end
  endtask

  // Monitor: drain the scoreboard on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) check_output(sb_q.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [AW-1:0] rwd;
    n_compared = 0;
    n_mismatched = 0;
    rst = 1'b1;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd9;
    model_clear();
    @(posedge clk);
    #1;
    reset_pulse();

    $display("[TB] write-then-read through bypass and array");
    apply_stimulus(5'd3, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3);
    apply_stimulus(5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd3);
    apply_stimulus(5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3);

    $display("[TB] register 0 is never written");
    apply_stimulus(5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
    apply_stimulus(5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
    apply_stimulus(5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);

    $display("[TB] stall holds, flush wins over stall");
    apply_stimulus(5'd5, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_stimulus(5'd6, 1'b1, 32'hBB, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd6);
    apply_stimulus(5'd6, 1'b1, 32'hBB, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd6);
    apply_stimulus(5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 5'd5);
    apply_stimulus(5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 5'd5);

    $display("[TB] dual-port bypass over stale array value");
    apply_stimulus(5'd7, 1'b1, 32'h1111, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_stimulus(5'd0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_stimulus(5'd7, 1'b1, 32'hCAFE, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7);
    apply_stimulus(5'd0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7);
    apply_stimulus(5'd0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7);

    $display("[TB] read disable");
    apply_stimulus(5'd4, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    apply_stimulus(5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd4);
    apply_stimulus(5'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd4);

    $display("[TB] fill all registers, then async reset");
    for (int i = 1; i < NREG; i++) begin
      apply_stimulus(AW'(i), 1'b1, $urandom | 32'h1, 1'b0, 1'b0,
                     1'b1, AW'(i), 1'b1, AW'(NREG - i));
    end
    apply_stimulus(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd31);
    wd_i = 5'd0; wreg_i = 1'b0; re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd2;
    reset_pulse();
    for (int i = 1; i < NREG; i++) begin
      apply_stimulus(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, AW'(i), 1'b1, AW'(NREG - i));
    end

    $display("[TB] randomized traffic");
    rwd = '0;
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        wd_i = AW'($urandom); wreg_i = 1'b1; wdata_i = $urandom;
        reset_pulse();
      end
      if ($urandom_range(0, 3) == 0) rwd = AW'($urandom);
      apply_stimulus(AW'($urandom), $urandom_range(0, 3) != 0, $urandom,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 5) != 0, ($urandom_range(0, 1) == 0) ? rwd : AW'($urandom),
                     $urandom_range(0, 5) != 0, ($urandom_range(0, 1) == 0) ? wb_wd_o : AW'($urandom));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
